serial: RTL and testbench
=========================

// Module: serial
// PURPOSE
//  UART front-end of the RISC-V debugger: receives framed command packets on srx and decodes them into
//  one debug request (debug_fn/addr/d_in) for the debug controller. Waits for the controller to
//  finish, then returns a reply on stx. Sits between the host UART pins and the debug controller.
// PARAMETERS
//  CLOCKS_PER_BIT  4  clk cycles per UART bit (8N1, LSB first); override for hardware baud rates
// PORTS
//  clk         in   1   system clock, all logic on rising edge
//  reset       in   1   asynchronous, active-low reset
//  srx         in   1   UART receive line, idle high (synchronise with 2 flops before use)
//  stx         out  1   UART transmit line, idle high
//  debug_fn    out  4   DEBUG_FN enum: decoded command, valid while out_valid=1
//  addr        out  32  decoded address (memory byte address or register index)
//  d_in        out  32  decoded write data
//  out_valid   out  1   one-cycle strobe: debug_fn/addr/d_in valid
//  ctrlr_busy  in   1   controller executing request; may be X/0 before first request
//  d_rd        in   32  read data from controller, sampled when ctrlr_busy falls
//  error       out  1   sticky: unknown command byte received; cleared by the next valid command byte
// BEHAVIOUR
//  Reset: stx=1, out_valid=0, error=0, debug_fn=NONE(0x0), addr=0, d_in=0; all FSMs go to IDLE;
//   any packet or reply in progress is discarded.
//  RX bit engine:
//   - Start is a high-to-low edge of synchronised srx.
//   - Bits are sampled mid-bit: first data bit at 1.5*CLOCKS_PER_BIT after the edge, then every CLOCKS_PER_BIT.
//   - 8 data bits, LSB first. Stop bit is not checked; the engine re-arms only after srx is seen high again.
//  Command bytes (DEBUG_FN), with extra bytes following; all multi-byte fields are MSB first:
//   0x01 PAUSE, 0x02 RESUME, 0x03 RESET_MCU, 0x0A STATUS: none
//   0x04 MEM_RD, 0x06 REG_RD, 0x08 ADD_BP, 0x09 RM_BP: addr[4]
//   0x05 MEM_WR, 0x07 REG_WR: addr[4] d_in[4]
//  Packet FSM: IDLE -> CMD -> ADDR(4 bytes) -> DATA(4 bytes) -> ISSUE -> WAIT_HI -> WAIT_LO -> REPLY -> IDLE
//   - States are skipped when the command carries no such field.
//   - Unknown command byte: error=1, stay in IDLE, no out_valid, no reply.
//  ISSUE:
//   - out_valid=1 for exactly 1 cycle, 2 cycles after the last data bit of the final packet byte is sampled.
//   - debug_fn/addr/d_in hold their values until the next ISSUE.
//   - Unused fields are 0.
//  Controller handshake:
//   - WAIT_HI waits for ctrlr_busy==1 (X or 0 ignored).
//   - WAIT_LO waits for ctrlr_busy==0; d_rd is latched on that cycle. No timeout; only reset aborts.
//  REPLY:
//   - Starts the cycle after busy falls.
//   - MEM_RD/REG_RD/STATUS: 4 bytes of latched d_rd, MSB first. All others: 1 byte echoing the command byte.
//  TX frame: start 0, 8 data bits LSB first, stop 1, each CLOCKS_PER_BIT cycles.
//   - Bytes are sent back to back; stx=1 between replies.
//  Bytes arriving on srx while FSM is past DATA are dropped; no queueing.
// TESTING
//  1 reset low mid-byte, release -> stx=1, out_valid=0, error=0; next byte 0x01 decodes normally
//  2 send 0x01; ctrlr_busy 1 for 10 cycles, then 0 -> one out_valid pulse, debug_fn=PAUSE, addr=0;
//    stx sends frame 0x01 after busy falls
//  3 send 05 00 00 10 00 DE AD BE EF; busy pulse -> addr=0x00001000, d_in=0xDEADBEEF, reply 0x05
//  4 send 04 00 00 00 20; d_rd=0x12345678 at busy fall -> stx sends 12 34 56 78
//  5 send 0xFF -> error=1, no out_valid, stx idle; then send 0x02 -> error=0, RESUME issued
//  6 low stop bit (srx 0 for stop period, then 1) -> byte accepted, no error

Source files
------------

// File: rtl/serial.sv
// UART front-end of the debugger: receives framed command packets on srx,
// decodes one debug request for the debug controller, waits for the
// controller to finish, and sends a reply frame sequence on stx.
//
// Internal byte handshake between the packet FSM and the transmitter:
// a byte moves when tx_valid and tx_ready are both high in the same cycle;
// the packet FSM holds tx_valid and keeps tx_data stable until that cycle,
// and the transmitter never accepts a byte without tx_valid.
module serial #(
    parameter int CLOCKS_PER_BIT = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        srx,
    output logic        stx,
    output logic [3:0]  debug_fn,
    output logic [31:0] addr,
    output logic [31:0] d_in,
    output logic        out_valid,
    input  logic        ctrlr_busy,
    input  logic [31:0] d_rd,
    output logic        error
);

    // Counter must hold the 1.5-bit start delay, which is the longest wait.
    localparam int START_WAIT = (3 * CLOCKS_PER_BIT) / 2;
    localparam int CNT_W      = (START_WAIT > 1) ? $clog2(START_WAIT) : 1;
    localparam logic [CNT_W-1:0] START_LOAD = CNT_W'(START_WAIT - 1);
    localparam logic [CNT_W-1:0] BIT_LOAD   = CNT_W'(CLOCKS_PER_BIT - 1);

    // Command classes: how many field bytes follow the command byte.
    localparam logic [1:0] K_BAD       = 2'd0;
    localparam logic [1:0] K_NONE      = 2'd1;
    localparam logic [1:0] K_ADDR      = 2'd2;
    localparam logic [1:0] K_ADDR_DATA = 2'd3;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_DATA,
        RX_REARM
    } rx_state_e;

    typedef enum logic {
        TX_IDLE,
        TX_SEND
    } tx_state_e;

    typedef enum logic [2:0] {
        P_IDLE,
        P_CMD,
        P_ADDR,
        P_DATA,
        P_ISSUE,
        P_WAIT_HI,
        P_WAIT_LO,
        P_REPLY
    } pkt_state_e;

    function automatic logic [1:0] cmd_kind(input logic [7:0] c);
        logic [1:0] k;
        case (c)
            8'h01, 8'h02, 8'h03, 8'h0A: k = K_NONE;
            8'h04, 8'h06, 8'h08, 8'h09: k = K_ADDR;
            8'h05, 8'h07:               k = K_ADDR_DATA;
            default:                    k = K_BAD;
        endcase
        return k;
    endfunction

    // Read-type commands answer with the four bytes returned by the controller.
    function automatic logic wide_reply(input logic [7:0] c);
        return (c == 8'h04) || (c == 8'h06) || (c == 8'h0A);
    endfunction

    // ------------------------------------------------------------------
    // srx synchroniser and falling-edge detect
    // ------------------------------------------------------------------
    logic srx_s1;
    logic srx_s2;
    logic srx_prev;
    logic srx_fall;

    // Two-flop synchroniser plus one history flop. Cleared to 0 so a line
    // that is low when reset lifts cannot look like a start edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            srx_s1   <= 1'b0;
            srx_s2   <= 1'b0;
            srx_prev <= 1'b0;
        end else begin
            srx_s1   <= srx;
            srx_s2   <= srx_s1;
            srx_prev <= srx_s2;
        end
    end

    assign srx_fall = srx_prev & ~srx_s2;

    // ------------------------------------------------------------------
    // RX bit engine
    // ------------------------------------------------------------------
    rx_state_e        rx_state;
    rx_state_e        rx_next;
    logic [CNT_W-1:0] rx_cnt;
    logic [2:0]       rx_bit;
    logic [7:0]       rx_shift;
    logic             rx_valid;
    logic             rx_start;

    assign rx_start = (rx_state == RX_IDLE) && srx_fall;

    // RX state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) rx_state <= RX_IDLE;
        else        rx_state <= rx_next;
    end

    // RX next state: start edge, eight mid-bit samples, then wait for a high line.
    always_comb begin
        rx_next = rx_state;
        case (rx_state)
            RX_IDLE:  if (srx_fall) rx_next = RX_DATA;
            RX_DATA:  if (rx_cnt == '0 && rx_bit == 3'd7) rx_next = RX_REARM;
            RX_REARM: if (srx_s2) rx_next = RX_IDLE;
            default:  rx_next = RX_IDLE;
        endcase
    end

    // RX datapath: bit timing, LSB-first shift, one-cycle byte strobe.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_cnt   <= '0;
            rx_bit   <= 3'd0;
            rx_shift <= 8'h00;
            rx_valid <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            case (rx_state)
                RX_IDLE: begin
                    if (srx_fall) begin
                        rx_cnt <= START_LOAD;
                        rx_bit <= 3'd0;
                    end
                end
                RX_DATA: begin
                    if (rx_cnt == '0) begin
                        rx_shift <= {srx_s2, rx_shift[7:1]};
                        rx_cnt   <= BIT_LOAD;
                        rx_bit   <= rx_bit + 3'd1;
                        if (rx_bit == 3'd7) rx_valid <= 1'b1;
                    end else begin
                        rx_cnt <= rx_cnt - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // TX frame engine
    // ------------------------------------------------------------------
    tx_state_e        tx_state;
    tx_state_e        tx_next;
    logic [9:0]       tx_frame;
    logic [3:0]       tx_bit;
    logic [CNT_W-1:0] tx_cnt;
    logic             tx_last;
    logic             tx_ready;
    logic             tx_valid;
    logic [7:0]       tx_data;

    // Ready during the final stop-bit cycle too, so reply bytes run back to back.
    assign tx_last  = (tx_state == TX_SEND) && (tx_bit == 4'd9) && (tx_cnt == '0);
    assign tx_ready = (tx_state == TX_IDLE) || tx_last;
    assign stx      = (tx_state == TX_SEND) ? tx_frame[0] : 1'b1;

    // TX state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) tx_state <= TX_IDLE;
        else        tx_state <= tx_next;
    end

    // TX next state: stay in SEND while bytes keep arriving at frame end.
    always_comb begin
        tx_next = tx_state;
        case (tx_state)
            TX_IDLE: if (tx_valid) tx_next = TX_SEND;
            TX_SEND: if (tx_last && !tx_valid) tx_next = TX_IDLE;
            default: tx_next = TX_IDLE;
        endcase
    end

    // TX datapath: load {stop, data, start} and shift out one bit per bit time.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tx_frame <= 10'h3FF;
            tx_bit   <= 4'd0;
            tx_cnt   <= '0;
        end else if (tx_valid && tx_ready) begin
            tx_frame <= {1'b1, tx_data, 1'b0};
            tx_bit   <= 4'd0;
            tx_cnt   <= BIT_LOAD;
        end else if (tx_state == TX_SEND) begin
            if (tx_cnt == '0) begin
                tx_cnt   <= BIT_LOAD;
                tx_bit   <= tx_bit + 4'd1;
                tx_frame <= {1'b1, tx_frame[9:1]};
            end else begin
                tx_cnt <= tx_cnt - 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Packet FSM
    // ------------------------------------------------------------------
    pkt_state_e pstate;
    pkt_state_e p_next;
    logic [7:0]  cmd_q;
    logic        has_data;
    logic        reply_four;
    logic [1:0]  byte_cnt;
    logic [1:0]  reply_idx;
    logic [31:0] addr_sh;
    logic [31:0] data_sh;
    logic [31:0] rd_q;
    logic [7:0]  rd_byte;

    // Reply byte selection, MSB first.
    always_comb begin
        rd_byte = rd_q[7:0];
        case (reply_idx)
            2'd0:    rd_byte = rd_q[31:24];
            2'd1:    rd_byte = rd_q[23:16];
            2'd2:    rd_byte = rd_q[15:8];
            default: rd_byte = rd_q[7:0];
        endcase
    end

    // Packet state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) pstate <= P_IDLE;
        else        pstate <= p_next;
    end

    // Packet next state and reply byte offer. A byte only enters CMD if its
    // start edge was seen while idle, so bytes that began during a request
    // are dropped rather than taken as the next command.
    always_comb begin
        p_next   = pstate;
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        case (pstate)
            P_IDLE: if (rx_start) p_next = P_CMD;
            P_CMD: begin
                if (rx_valid) begin
                    case (cmd_kind(rx_shift))
                        K_NONE:  p_next = P_ISSUE;
                        K_ADDR, K_ADDR_DATA: p_next = P_ADDR;
                        default: p_next = P_IDLE;
                    endcase
                end
            end
            P_ADDR: begin
                if (rx_valid && byte_cnt == 2'd3) p_next = has_data ? P_DATA : P_ISSUE;
            end
            P_DATA: begin
                if (rx_valid && byte_cnt == 2'd3) p_next = P_ISSUE;
            end
            P_ISSUE:   p_next = P_WAIT_HI;
            P_WAIT_HI: if (ctrlr_busy == 1'b1) p_next = P_WAIT_LO;
            P_WAIT_LO: if (ctrlr_busy == 1'b0) p_next = P_REPLY;
            P_REPLY: begin
                tx_valid = 1'b1;
                tx_data  = reply_four ? rd_byte : cmd_q;
                if (tx_ready && (!reply_four || reply_idx == 2'd3)) p_next = P_IDLE;
            end
            default: p_next = P_IDLE;
        endcase
    end

    // Packet datapath: field assembly, request outputs, sticky error, read latch.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cmd_q      <= 8'h00;
            has_data   <= 1'b0;
            reply_four <= 1'b0;
            byte_cnt   <= 2'd0;
            reply_idx  <= 2'd0;
            addr_sh    <= 32'h0;
            data_sh    <= 32'h0;
            rd_q       <= 32'h0;
            out_valid  <= 1'b0;
            debug_fn   <= 4'h0;
            addr       <= 32'h0;
            d_in       <= 32'h0;
            error      <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            case (pstate)
                P_CMD: begin
                    if (rx_valid) begin
                        cmd_q      <= rx_shift;
                        error      <= (cmd_kind(rx_shift) == K_BAD);
                        has_data   <= (cmd_kind(rx_shift) == K_ADDR_DATA);
                        reply_four <= wide_reply(rx_shift);
                        byte_cnt   <= 2'd0;
                        reply_idx  <= 2'd0;
                        addr_sh    <= 32'h0;
                        data_sh    <= 32'h0;
                    end
                end
                P_ADDR: begin
                    if (rx_valid) begin
                        addr_sh  <= {addr_sh[23:0], rx_shift};
                        byte_cnt <= byte_cnt + 2'd1;
                    end
                end
                P_DATA: begin
                    if (rx_valid) begin
                        data_sh  <= {data_sh[23:0], rx_shift};
                        byte_cnt <= byte_cnt + 2'd1;
                    end
                end
                P_ISSUE: begin
                    out_valid <= 1'b1;
                    debug_fn  <= cmd_q[3:0];
                    addr      <= addr_sh;
                    d_in      <= data_sh;
                end
                P_WAIT_LO: begin
                    if (ctrlr_busy == 1'b0) rd_q <= d_rd;
                end
                P_REPLY: begin
                    if (tx_ready) reply_idx <= reply_idx + 2'd1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial.sv
// Bench for serial: drives UART frames on srx, plays the debug controller
// on ctrlr_busy/d_rd, decodes stx frames and checks them against expected bytes.
module tb_serial;

    localparam int CPB = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        srx = 1'b1;
    logic        stx;
    logic [3:0]  debug_fn;
    logic [31:0] addr;
    logic [31:0] d_in;
    logic        out_valid;
    logic        ctrlr_busy = 1'b0;
    logic [31:0] d_rd = 32'h0;
    logic        error;

    int errors = 0;
    int checks = 0;
    int ov_cnt = 0;
    logic [3:0]  cap_fn = 4'h0;
    logic [31:0] cap_addr = 32'h0;
    logic [31:0] cap_din = 32'h0;
    logic [7:0]  exp_q[$];
    logic [7:0]  mon_byte;
    logic [7:0]  mon_exp;

    // bytes: first packet byte in [71:64]; rep: first reply byte in [31:24]
    typedef struct packed {
        logic [71:0] bytes;
        logic [3:0]  n;
        logic        issue;
        logic [3:0]  fn;
        logic [31:0] a;
        logic [31:0] din;
        logic [31:0] rd;
        logic [31:0] rep;
        logic [2:0]  rep_n;
        logic        err;
    } vec_t;

    vec_t vecs[9];
    vec_t low_stop_vec;

    serial #(.CLOCKS_PER_BIT(CPB)) dut (
        .clk        (clk),
        .reset      (reset),
        .srx        (srx),
        .stx        (stx),
        .debug_fn   (debug_fn),
        .addr       (addr),
        .d_in       (d_in),
        .out_valid  (out_valid),
        .ctrlr_busy (ctrlr_busy),
        .d_rd       (d_rd),
        .error      (error)
    );

    // clock
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // out_valid monitor: counts high cycles, captures the request fields
    initial begin
        forever begin
            @(negedge clk);
            if (out_valid === 1'b1) begin
                ov_cnt++;
                cap_fn   = debug_fn;
                cap_addr = addr;
                cap_din  = d_in;
            end
        end
    end

    // stx decoder and scoreboard
    initial begin
        forever begin
            @(negedge clk);
            if (stx === 1'b0) begin
                repeat (CPB / 2) @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) @(negedge clk);
                    mon_byte[i] = stx;
                end
                repeat (CPB) @(negedge clk);
                check("stx_stop_bit", {31'h0, stx}, 32'h1);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL stx_unexpected_byte: got %h expected no byte", mon_byte);
                end else begin
                    mon_exp = exp_q.pop_front();
                    check("stx_byte", {24'h0, mon_byte}, {24'h0, mon_exp});
                end
            end
        end
    end

    // watchdog
    initial begin
        repeat (60000) @(posedge clk);
        $display("FAIL watchdog: cycle budget exhausted, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end

    task automatic drive_bit(input logic v);
        srx = v;
        repeat (CPB) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_val);
        @(posedge clk);
        #1;
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
        drive_bit(stop_val);
        drive_bit(1'b1);
        drive_bit(1'b1);
    endtask

    task automatic busy_rise();
        @(posedge clk);
        #1 ctrlr_busy = 1'b1;
    endtask

    // drop busy with read data valid only on the falling cycle
    task automatic busy_fall(input logic [31:0] rd, input int idx);
        int t;
        @(posedge clk);
        #1;
        ctrlr_busy = 1'b0;
        d_rd = rd;
        @(posedge clk);
        #1 d_rd = 32'hBAD0BAD0;
        t = 0;
        @(negedge clk);
        while (stx !== 1'b0 && t < 4) begin
            @(negedge clk);
            t++;
        end
        check($sformatf("v%0d_reply_start", idx), {31'h0, stx}, 32'h0);
    endtask

    task automatic wait_ov(input int ov0);
        int t;
        t = 0;
        while (ov_cnt == ov0 && t < 40) begin
            @(posedge clk);
            t++;
        end
    endtask

    task automatic wait_reply();
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 400) begin
            @(posedge clk);
            t++;
        end
        repeat (3 * CPB) @(posedge clk);
    endtask

    task automatic run_vec(input int idx, input vec_t v, input logic stop_val);
        int ov0;
        ov0 = ov_cnt;
        for (int i = 0; i < int'(v.rep_n); i++) exp_q.push_back(v.rep[31 - 8 * i -: 8]);
        for (int i = 0; i < int'(v.n); i++) send_byte(v.bytes[71 - 8 * i -: 8], stop_val);
        if (v.issue) begin
            wait_ov(ov0);
            busy_rise();
            repeat (10) @(posedge clk);
            busy_fall(v.rd, idx);
        end else begin
            repeat (60) @(posedge clk);
        end
        wait_reply();
        check($sformatf("v%0d_out_valid_cycles", idx), 32'(ov_cnt - ov0), {31'h0, v.issue});
        if (v.issue) begin
            check($sformatf("v%0d_cap_fn", idx), {28'h0, cap_fn}, {28'h0, v.fn});
            check($sformatf("v%0d_cap_addr", idx), cap_addr, v.a);
            check($sformatf("v%0d_cap_din", idx), cap_din, v.din);
        end
        @(negedge clk);
        check($sformatf("v%0d_debug_fn_held", idx), {28'h0, debug_fn}, {28'h0, v.fn});
        check($sformatf("v%0d_addr_held", idx), addr, v.a);
        check($sformatf("v%0d_d_in_held", idx), d_in, v.din);
        check($sformatf("v%0d_error", idx), {31'h0, error}, {31'h0, v.err});
        check($sformatf("v%0d_reply_missing", idx), 32'(exp_q.size()), 32'h0);
        exp_q.delete();
    endtask

    initial begin
        int ov0;
        // bytes, n, issue, fn, addr, d_in, d_rd, reply, reply_n, error
        vecs[0] = '{72'h01_0000000000000000, 4'd1, 1'b1, 4'h1, 32'h0, 32'h0,
                    32'h0, 32'h01000000, 3'd1, 1'b0};
        vecs[1] = '{72'h05_00001000_DEADBEEF, 4'd9, 1'b1, 4'h5, 32'h00001000, 32'hDEADBEEF,
                    32'h0, 32'h05000000, 3'd1, 1'b0};
        vecs[2] = '{72'h04_00000020_00000000, 4'd5, 1'b1, 4'h4, 32'h00000020, 32'h0,
                    32'h12345678, 32'h12345678, 3'd4, 1'b0};
        vecs[3] = '{72'hFF_0000000000000000, 4'd1, 1'b0, 4'h4, 32'h00000020, 32'h0,
                    32'h0, 32'h0, 3'd0, 1'b1};
        vecs[4] = '{72'h02_0000000000000000, 4'd1, 1'b1, 4'h2, 32'h0, 32'h0,
                    32'h0, 32'h02000000, 3'd1, 1'b0};
        vecs[5] = '{72'h0A_0000000000000000, 4'd1, 1'b1, 4'hA, 32'h0, 32'h0,
                    32'hCAFEF00D, 32'hCAFEF00D, 3'd4, 1'b0};
        vecs[6] = '{72'h06_0000001F_00000000, 4'd5, 1'b1, 4'h6, 32'h0000001F, 32'h0,
                    32'h89ABCDEF, 32'h89ABCDEF, 3'd4, 1'b0};
        vecs[7] = '{72'h07_00000003_01020304, 4'd9, 1'b1, 4'h7, 32'h00000003, 32'h01020304,
                    32'h0, 32'h07000000, 3'd1, 1'b0};
        vecs[8] = '{72'h08_80000100_00000000, 4'd5, 1'b1, 4'h8, 32'h80000100, 32'h0,
                    32'h0, 32'h08000000, 3'd1, 1'b0};
        low_stop_vec = '{72'h03_0000000000000000, 4'd1, 1'b1, 4'h3, 32'h0, 32'h0,
                         32'h0, 32'h03000000, 3'd1, 1'b0};

        // reset, then abort a half-received packet with a second reset
        repeat (5) @(posedge clk);
        #1 reset = 1'b1;
        repeat (4) @(posedge clk);
        send_byte(8'h04, 1'b1);
        send_byte(8'h00, 1'b1);
        @(posedge clk);
        #1 srx = 1'b0;
        repeat (3 * CPB) @(posedge clk);
        #1 reset = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        repeat (6) @(posedge clk);
        @(negedge clk);
        check("rst_stx", {31'h0, stx}, 32'h1);
        check("rst_out_valid", {31'h0, out_valid}, 32'h0);
        check("rst_error", {31'h0, error}, 32'h0);
        check("rst_debug_fn", {28'h0, debug_fn}, 32'h0);
        check("rst_addr", addr, 32'h0);
        check("rst_d_in", d_in, 32'h0);
        #1 srx = 1'b1;
        repeat (12) @(posedge clk);
        check("rst_no_issue", 32'(ov_cnt), 32'h0);

        // table-driven packets
        for (int i = 0; i < 9; i++) run_vec(i, vecs[i], 1'b1);

        // byte arriving while the controller is busy is dropped
        ov0 = ov_cnt;
        exp_q.push_back(8'h09);
        send_byte(8'h09, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h44, 1'b1);
        wait_ov(ov0);
        busy_rise();
        send_byte(8'h01, 1'b1);
        busy_fall(32'h0, 20);
        wait_reply();
        @(negedge clk);
        check("drop_out_valid_cycles", 32'(ov_cnt - ov0), 32'h1);
        check("drop_debug_fn", {28'h0, debug_fn}, 32'h9);
        check("drop_addr", addr, 32'h00000044);
        check("drop_error", {31'h0, error}, 32'h0);
        check("drop_reply_missing", 32'(exp_q.size()), 32'h0);
        exp_q.delete();

        // low stop bit still accepted, and the receiver re-arms afterwards
        run_vec(21, low_stop_vec, 1'b0);
        run_vec(22, vecs[4], 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
